// File: rtl/systolic_skew_feeder_if.sv
// Bundle between an upstream vector source and the systolic skew feeder.
// The feeder takes the slave side: it consumes the vector handshake and
// drives the PE-edge lanes and the shared en/sync/done controls.
// Optional macro FEEDER_BUBBLE_STATS_EN adds the o_bubble_cnt statistic.
interface systolic_skew_feeder_if #(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [N*W-1:0]   i_data;
  logic             i_last;
  logic [N*W-1:0]   o_data;
  logic             o_en;
  logic             o_sync;
  logic             o_done;
  logic [CNT_W-1:0] o_beat_cnt;
`ifdef FEEDER_BUBBLE_STATS_EN
  logic [CNT_W-1:0] o_bubble_cnt;

  modport slave (
    input  i_valid, i_data, i_last,
    output o_ready, o_data, o_en, o_sync, o_done, o_beat_cnt, o_bubble_cnt
  );

  modport master (
    output i_valid, i_data, i_last,
    input  o_ready, o_data, o_en, o_sync, o_done, o_beat_cnt, o_bubble_cnt
  );
`else
  modport slave (
    input  i_valid, i_data, i_last,
    output o_ready, o_data, o_en, o_sync, o_done, o_beat_cnt
  );

  modport master (
    output i_valid, i_data, i_last,
    input  o_ready, o_data, o_en, o_sync, o_done, o_beat_cnt
  );
`endif
endinterface

// File: rtl/systolic_skew_feeder.sv
// Input-staging stage in front of one edge of a systolic array.
// Each accepted N-lane vector is skewed diagonally (lane k delayed k extra
// cycles) and presented to the edge PEs together with the shared en/sync
// controls. en stays high for the whole tile; stalls become zero bubbles.
// Optional macro FEEDER_BUBBLE_STATS_EN adds o_bubble_cnt (stall count).
module systolic_skew_feeder #(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input logic                   i_clk,
  input logic                   i_rst,
  systolic_skew_feeder_if.slave bus
);

  localparam int DRN_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // With a single lane nothing trails the last beat, so no drain is needed.
  localparam logic [1:0]       ST_AFTER_LAST = (N > 1) ? ST_DRAIN : ST_DONE;
  localparam logic [DRN_W-1:0] DRN_LOAD      = DRN_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  logic [1:0]       state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             en_q, en_d;
  logic             sync_q, sync_d;
  logic             done_q, done_d;

  logic             ready;
  logic             accept;
  logic             advance;
  logic [N*W-1:0]   shift_in;

  // Ready depends on state only, so upstream sees it in the same cycle.
  assign ready    = !i_rst && (state_q == ST_IDLE || state_q == ST_STREAM);
  assign accept   = bus.i_valid && ready;
  // The chain moves on an accept and for every STREAM/DRAIN cycle; idle
  // and done cycles load zeros so the edge sees a clean zero vector.
  assign advance  = accept || state_q == ST_STREAM || state_q == ST_DRAIN;
  assign shift_in = accept ? bus.i_data : '0;

  // Tile sequencing: next state, drain countdown, beat count, PE controls.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d    = state_q;
    drain_d    = drain_q;
    beat_cnt_d = beat_cnt_q;
    en_d       = 1'b0;
    sync_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          en_d       = 1'b1;
          sync_d     = 1'b1;
          beat_cnt_d = CNT_W'(1);
          drain_d    = DRN_LOAD;
          state_d    = bus.i_last ? ST_AFTER_LAST : ST_STREAM;
        end
      end
      ST_STREAM: begin
        en_d = 1'b1;
        if (accept) begin
          if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (bus.i_last) begin
            drain_d = DRN_LOAD;
            state_d = ST_AFTER_LAST;
          end
        end
      end
      ST_DRAIN: begin
        en_d    = 1'b1;
        drain_d = drain_q - 1'b1;
        if (drain_q == DRN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any tile in progress without o_done.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q    <= ST_IDLE;
      drain_q    <= '0;
      beat_cnt_q <= '0;
      en_q       <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      beat_cnt_q <= beat_cnt_d;
      en_q       <= en_d;
      sync_q     <= sync_d;
      done_q     <= done_d;
    end
  end

  // Diagonal skew: lane k is a shift chain of depth k+1.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [W-1:0] pipe_q [0:k];
    logic [W-1:0] pipe_d [0:k];

    // Shift the lane's slice in at stage 0, or flush to zero when idle.
    always_comb begin
      for (int s = 0; s <= k; s++) begin
        pipe_d[s] = '0;
      end
      if (advance) begin
        pipe_d[0] = shift_in[k*W +: W];
        for (int s = 1; s <= k; s++) begin
          pipe_d[s] = pipe_q[s-1];
        end
      end
    end

    // Skew chain registers.
    always_ff @(posedge i_clk) begin
      // NOTE: these stages feed the PE edge directly, so they are reset like
      // any control flop rather than left as an unreset data memory.
      if (i_rst) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign bus.o_data[k*W +: W] = pipe_q[k];
  end

`ifdef FEEDER_BUBBLE_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Count zero bubbles inserted while streaming; restart with each tile.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (state_q == ST_IDLE && accept) begin
      bubble_cnt_d = '0;
    end else if (state_q == ST_STREAM && !accept && bubble_cnt_q != CNT_MAX) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  // Bubble statistic register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.o_bubble_cnt = bubble_cnt_q;
`endif

  assign bus.o_ready    = ready;
  assign bus.o_en       = en_q;
  assign bus.o_sync     = sync_q;
  assign bus.o_done     = done_q;
  assign bus.o_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a directed vector table, hand-written
// corner sequences, a single-lane instance with a narrow counter, and
// random traffic against a timestamp-based reference model.
module tb_systolic_skew_feeder;

  localparam int W      = 16;
  localparam int N      = 4;
  localparam int CNT_W  = 16;
  localparam int N1     = 1;
  localparam int CNT1_W = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.W(W), .N(N),  .CNT_W(CNT_W))  bus  ();
  systolic_skew_feeder_if #(.W(W), .N(N1), .CNT_W(CNT1_W)) bus1 ();

  systolic_skew_feeder #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  systolic_skew_feeder #(.W(W), .N(N1), .CNT_W(CNT1_W)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] p4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  typedef struct {
    bit             rst;
    bit             v;
    bit             last;
    logic [N*W-1:0] d;
    bit             e_ready;
    bit             e_en;
    bit             e_sync;
    bit             e_done;
    int             e_cnt;
    logic [N*W-1:0] e_data;
  } vec_t;

  // Reference model: a tile is described by the cycle of its first accept
  // and the cycle of its last accept; every control output follows from
  // those two timestamps. Lane k shows the vector shifted in k+1 cycles ago.
  int             t;
  int             first_c;
  int             last_c;
  int             m_cnt;
  int             m_bub;
  logic [N*W-1:0] hist [$];
  int             en_seen;
  int             done_seen;

  task automatic model_reset();
    first_c = -1;
    last_c  = -1;
    m_cnt   = 0;
    m_bub   = 0;
    hist    = {};
    for (int k = 0; k < N; k++) hist.push_back('0);
  endtask

  // One clock cycle on the N=4 instance: drive, check against the model,
  // clock, advance the model.
  task automatic tick(input bit r, input bit v, input bit l,
                      input logic [N*W-1:0] d, output bit acc);
    bit             e_ready, e_en, e_sync, e_done, in_stream;
    logic [N*W-1:0] e_data;
    rst         = r;
    bus.i_valid = v;
    bus.i_last  = l;
    bus.i_data  = d;
    #1;
    e_ready = !r && !(last_c >= 0 && t > last_c && t <= last_c + N);
    e_en    = first_c >= 0 && t > first_c && (last_c < 0 || t <= last_c + N);
    e_sync  = first_c >= 0 && t == first_c + 1;
    e_done  = last_c >= 0 && t == last_c + N + 1;
    e_data  = '0;
    for (int k = 0; k < N; k++) e_data[k*W +: W] = hist[k][k*W +: W];
    check($sformatf("c%0d ready", t), bus.o_ready, e_ready);
    check($sformatf("c%0d en", t), bus.o_en, e_en);
    check($sformatf("c%0d sync", t), bus.o_sync, e_sync);
    check($sformatf("c%0d done", t), bus.o_done, e_done);
    check($sformatf("c%0d beat_cnt", t), bus.o_beat_cnt, m_cnt);
    check($sformatf("c%0d data", t), bus.o_data, e_data);
`ifdef FEEDER_BUBBLE_STATS_EN
    check($sformatf("c%0d bubble_cnt", t), bus.o_bubble_cnt, m_bub);
`endif
    if (bus.o_en === 1'b1) en_seen++;
    if (bus.o_done === 1'b1) done_seen++;
    acc       = v && e_ready;
    in_stream = first_c >= 0 && last_c < 0;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (acc) begin
        if (in_stream) begin
          if (m_cnt < CMAX) m_cnt++;
        end else begin
          first_c = t;
          last_c  = -1;
          m_cnt   = 1;
          m_bub   = 0;
        end
        if (l) last_c = t;
      end else if (in_stream && m_bub < CMAX) begin
        m_bub++;
      end
      hist.push_front(acc ? d : '0);
      void'(hist.pop_back());
    end
    t++;
    @(negedge clk);
  endtask

  initial begin
    vec_t           tbl [22];
    bit             acc;
    bit             v, l, r, hold;
    logic [N*W-1:0] d;

    bus.i_valid  = 1'b0;
    bus.i_last   = 1'b0;
    bus.i_data   = '0;
    bus1.i_valid = 1'b0;
    bus1.i_last  = 1'b0;
    bus1.i_data  = '0;
    t = 0;
    en_seen = 0;
    done_seen = 0;
    model_reset();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // rst v last data | ready en sync done cnt data
    tbl[0]  = '{1, 0, 0, '0,              0, 0, 0, 0, 0, '0};
    tbl[1]  = '{0, 1, 0, p4(1, 2, 3, 4),  1, 0, 0, 0, 0, '0};
    tbl[2]  = '{0, 1, 0, p4(2, 4, 6, 8),  1, 1, 1, 0, 1, p4(1, 0, 0, 0)};
    tbl[3]  = '{0, 1, 0, p4(3, 6, 9, 12), 1, 1, 0, 0, 2, p4(2, 2, 0, 0)};
    tbl[4]  = '{0, 1, 1, p4(4, 8, 12, 16),1, 1, 0, 0, 3, p4(3, 4, 3, 0)};
    tbl[5]  = '{0, 0, 0, '0,              0, 1, 0, 0, 4, p4(4, 6, 6, 4)};
    tbl[6]  = '{0, 0, 0, '0,              0, 1, 0, 0, 4, p4(0, 8, 9, 8)};
    tbl[7]  = '{0, 0, 0, '0,              0, 1, 0, 0, 4, p4(0, 0, 12, 12)};
    tbl[8]  = '{0, 0, 0, '0,              0, 1, 0, 0, 4, p4(0, 0, 0, 16)};
    tbl[9]  = '{0, 1, 1, p4(7, 7, 7, 7),  1, 0, 0, 1, 4, '0};
    tbl[10] = '{0, 1, 1, p4(5, 6, 7, 8),  0, 1, 1, 0, 1, p4(7, 0, 0, 0)};
    tbl[11] = '{0, 1, 1, p4(5, 6, 7, 8),  0, 1, 0, 0, 1, p4(0, 7, 0, 0)};
    tbl[12] = '{0, 1, 1, p4(5, 6, 7, 8),  0, 1, 0, 0, 1, p4(0, 0, 7, 0)};
    tbl[13] = '{0, 1, 1, p4(5, 6, 7, 8),  0, 1, 0, 0, 1, p4(0, 0, 0, 7)};
    tbl[14] = '{0, 1, 1, p4(5, 6, 7, 8),  1, 0, 0, 1, 1, '0};
    tbl[15] = '{0, 0, 0, '0,              0, 1, 1, 0, 1, p4(5, 0, 0, 0)};
    tbl[16] = '{0, 0, 0, '0,              0, 1, 0, 0, 1, p4(0, 6, 0, 0)};
    tbl[17] = '{0, 0, 0, '0,              0, 1, 0, 0, 1, p4(0, 0, 7, 0)};
    tbl[18] = '{0, 0, 0, '0,              0, 1, 0, 0, 1, p4(0, 0, 0, 8)};
    tbl[19] = '{0, 0, 1, '0,              1, 0, 0, 1, 1, '0};
    tbl[20] = '{1, 1, 0, p4(9, 9, 9, 9),  0, 0, 0, 0, 1, '0};
    tbl[21] = '{1, 0, 0, '0,              0, 0, 0, 0, 0, '0};

    for (int i = 0; i < 22; i++) begin
      rst         = tbl[i].rst;
      bus.i_valid = tbl[i].v;
      bus.i_last  = tbl[i].last;
      bus.i_data  = tbl[i].d;
      #1;
      check($sformatf("tbl%0d ready", i), bus.o_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d en", i), bus.o_en, tbl[i].e_en);
      check($sformatf("tbl%0d sync", i), bus.o_sync, tbl[i].e_sync);
      check($sformatf("tbl%0d done", i), bus.o_done, tbl[i].e_done);
      check($sformatf("tbl%0d beat_cnt", i), bus.o_beat_cnt, tbl[i].e_cnt);
      check($sformatf("tbl%0d data", i), bus.o_data, tbl[i].e_data);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset held two cycles in the middle of a stream.
    repeat (3) tick(0, 1, 0, {$urandom, $urandom}, acc);
    repeat (2) tick(1, 1, 0, {$urandom, $urandom}, acc);
    done_seen = 0;
    repeat (6) tick(0, 0, 0, '0, acc);
    check("rst_mid_stream no done", done_seen, 0);

    // Tile with a two-cycle upstream stall after beat 2.
    en_seen   = 0;
    done_seen = 0;
    tick(0, 1, 0, p4(1, 2, 3, 4), acc);
    tick(0, 1, 0, p4(2, 4, 6, 8), acc);
    tick(0, 0, 0, '0, acc);
    tick(0, 0, 0, '0, acc);
    tick(0, 1, 0, p4(3, 6, 9, 12), acc);
    tick(0, 1, 1, p4(4, 8, 12, 16), acc);
    repeat (6) tick(0, 0, 0, '0, acc);
    check("stall en cycles", en_seen, 9);
    check("stall done pulses", done_seen, 1);
    check("stall beat_cnt", bus.o_beat_cnt, 4);
`ifdef FEEDER_BUBBLE_STATS_EN
    check("stall bubble_cnt", bus.o_bubble_cnt, 2);
`endif

    // Single-lane instance: no drain, done right after the single en cycle.
    bus1.i_valid = 1'b1;
    bus1.i_last  = 1'b1;
    bus1.i_data  = 16'h0007;
    tick(0, 0, 0, '0, acc);
    bus1.i_valid = 1'b0;
    bus1.i_last  = 1'b0;
    check("n1 en", bus1.o_en, 1);
    check("n1 sync", bus1.o_sync, 1);
    check("n1 ready in done", bus1.o_ready, 0);
    check("n1 data", bus1.o_data, 16'h0007);
    check("n1 done early", bus1.o_done, 0);
    tick(0, 0, 0, '0, acc);
    check("n1 en after", bus1.o_en, 0);
    check("n1 done", bus1.o_done, 1);
    check("n1 ready idle", bus1.o_ready, 1);
    check("n1 data flushed", bus1.o_data, 0);
    check("n1 beat_cnt", bus1.o_beat_cnt, 1);

    // Single-lane instance with a 3-bit counter: 9 beats and 8 bubbles saturate.
    for (int i = 0; i < 9; i++) begin
      bus1.i_valid = 1'b1;
      bus1.i_last  = (i == 8);
      bus1.i_data  = W'(i + 1);
      tick(0, 0, 0, '0, acc);
      if (i < 8) begin
        bus1.i_valid = 1'b0;
        tick(0, 0, 0, '0, acc);
      end
    end
    bus1.i_valid = 1'b0;
    bus1.i_last  = 1'b0;
    check("n1 sat last data", bus1.o_data, 9);
    check("n1 sat en", bus1.o_en, 1);
    tick(0, 0, 0, '0, acc);
    check("n1 sat done", bus1.o_done, 1);
    check("n1 sat beat_cnt", bus1.o_beat_cnt, 7);
`ifdef FEEDER_BUBBLE_STATS_EN
    check("n1 sat bubble_cnt", bus1.o_bubble_cnt, 7);
`endif

    // Random traffic; upstream holds a refused beat until it is taken.
    hold = 1'b0;
    v    = 1'b0;
    l    = 1'b0;
    d    = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 9) < 6);
        l = v && ($urandom_range(0, 4) == 0);
        d = {$urandom, $urandom};
      end
      r = ($urandom_range(0, 299) == 0);
      tick(r, v, l, d, acc);
      hold = v && !acc && !r;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Input-staging stage directly upstream of a PE row/column edge of the systolic array.
- Accepts one N-lane operand vector per handshake and applies a diagonal skew: lane k is delayed k extra cycles. Drives edge PEs' A (or B) inputs plus the shared en/sync controls.
- PEs clear their accumulator whenever en is low, so the feeder keeps en high for the whole tile. Input stalls are filled with zero bubbles, which add nothing to the MAC sums.

Parameters:
- W, 16, operand width per lane.
- N, 4, number of lanes (array edge length), N >= 1.
- CNT_W, 16, width of the tile beat counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input vector valid.
- o_ready  out  1  feeder can accept a vector this cycle.
- i_data  in  N*W  lane k = bits [k*W +: W].
- i_last  in  1  qualifies the final vector of a tile (sampled with i_valid&o_ready).
- o_data  out  N*W  skewed lanes to the PE edge (registered).
- o_en  out  1  PE enable (registered).
- o_sync  out  1  one-cycle accumulator-clear pulse at tile start (registered).
- o_done  out  1  one-cycle pulse: tile fully flushed.
- o_beat_cnt  out  CNT_W  accepted beats in current/last tile.

Behaviour:
- Clock/reset: single clock i_clk; i_rst synchronous, active-high.
- Reset values: all skew regs 0, o_data 0, o_en 0, o_sync 0, o_done 0, o_beat_cnt 0, state IDLE. o_ready is 0 during the reset cycle.
- Reset mid-tile: aborts immediately; no o_done is produced.
- Skew:
  - Lane k is a shift chain of depth k+1.
  - o_data lane k at cycle t = the value shifted in at cycle t-1-k.
  - Latency: lane 0 = 1 cycle, lane k = k+1 cycles.
- Shift-in value per cycle:
  - In STREAM: i_data if accepted, else 0 (bubble).
  - In DRAIN: 0.
  - In IDLE/DONE: the chain is not advanced and is held at 0.
- Accept condition: beat accepted iff i_valid & o_ready.
- o_ready is combinational from state: 1 in IDLE and STREAM, 0 in DRAIN and DONE.
- States:
  - IDLE: o_en=0.
    - Accept with i_last=0 -> STREAM.
    - Accept with i_last=1 -> DRAIN (N>1) or DONE (N=1).
    - On any accept: o_sync=1 and o_en=1 next cycle, o_beat_cnt=1.
  - STREAM: o_en=1 every cycle.
    - Each accept increments o_beat_cnt, saturating at all-ones.
    - Accept with i_last=1 -> DRAIN (N>1) or DONE (N=1); drain counter loaded with N-1.
  - DRAIN: o_en=1; shifts zeros for exactly N-1 cycles; then -> DONE.
  - DONE: one cycle.
    - o_done=1, o_en=0.
    - The last skewed element (lane N-1) was presented the previous cycle.
    - -> IDLE.
- o_sync is asserted together with the first cycle of o_en=1 only. It is never asserted mid-tile.
- o_beat_cnt holds its value after DONE until the next tile's first accept, which reloads it to 1.
- i_last without i_valid is ignored. i_valid while o_ready=0 is not consumed; the upstream must hold it.
- The first beat of a new tile can be accepted in the cycle after DONE (IDLE). Back-to-back tiles therefore have one en-low gap, which clears the PEs.

Optional Feature:
- Macro FEEDER_BUBBLE_STATS_EN.
- Defined: adds output o_bubble_cnt (CNT_W).
  - Cleared on reset and on a tile's first accept.
  - Increments, saturating, for each STREAM cycle with no accept (zero inserted).
  - Held after DONE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold i_rst 2 cycles mid-STREAM -> o_data=0, o_en=0, o_ready=1 after release, no o_done; counters 0.
- N=4, W=16, four back-to-back beats, lane values {1,2,3,4}*beat (beat 4 with i_last) -> o_sync on first o_en cycle; lane k shows beat b values at cycle b+k. o_en high 4+3=7 cycles, o_done in cycle 8, o_beat_cnt=4.
- Same tile with i_valid dropped 2 cycles after beat 2 -> lane 0 shows 2 zero cycles between beat 2 and beat 3; o_en stays high throughout (9 cycles). With macro: o_bubble_cnt=2.
- Single beat with i_last in IDLE, data 0x0007 on all lanes -> lane k = 7 at cycle k+1; DRAIN 3 cycles, o_done then IDLE, o_beat_cnt=1.
- Upstream holds i_valid=1 during DRAIN/DONE -> o_ready=0, beat not consumed, accepted in the IDLE cycle after DONE with fresh o_sync.
- N=1 parameterisation: beat with i_last -> no DRAIN; o_en 1 cycle, o_done the next cycle.
